// File: rtl/alu_mul_seq_pkg.sv
// Shared CPU types: data word, ALU operation codes and the multiply sequencer state.
package cpu_types_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [3:0] {
    ALU_SLL,
    ALU_SRL,
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_NOR,
    ALU_SLT,
    ALU_SLTU
  } aluop_t;

  typedef enum logic [1:0] {
    MUL_IDLE,
    MUL_RUN,
    MUL_DONE
  } mulstate_t;

endpackage

// File: rtl/alu_mul_seq_if.sv
// Multiply request/response bundle between the execute stage (master) and the sequencer (slave).
interface alu_mul_seq_if
  import cpu_types_pkg::*;
();
  logic  start;
  word_t multiplicand;
  word_t multiplier;
  logic  busy;
  logic  done;
  word_t product;

  modport master (
    output start, multiplicand, multiplier,
    input  busy, done, product
  );

  modport slave (
    input  start, multiplicand, multiplier,
    output busy, done, product
  );
endinterface

// File: rtl/alu_mul_seq.sv
// Shift-and-add multiply sequencer that borrows the shared ALU for one ADD per iteration
// and otherwise passes the execute-stage ALU operands straight through.
module alu_mul_seq
  import cpu_types_pkg::*;
(
  input  logic          CLK,
  input  logic          nRST,
  alu_mul_seq_if.slave  mul,
  input  word_t         ex_portA,
  input  word_t         ex_portB,
  input  aluop_t        ex_aluOp,
  output logic          ex_stall,
  output word_t         alu_portA,
  output word_t         alu_portB,
  output aluop_t        alu_aluOp,
  input  word_t         alu_outPort,
  input  logic          alu_negative,
  input  logic          alu_overflow,
  input  logic          alu_zero
);

  mulstate_t  state;
  word_t      mcand;
  word_t      mplier;
  word_t      acc;
  logic [4:0] cnt;

  word_t acc_next;
  logic  run_exit;

  // ALU flags carry no meaning for a modulo-2^32 low-word product.
  logic unused_flags;
  assign unused_flags = alu_negative ^ alu_overflow ^ alu_zero;

  assign ex_stall = mul.busy;

  always_comb begin
    acc_next = mplier[0] ? alu_outPort : acc;
    // Stop once no set bits remain above the one consumed this cycle.
    run_exit = (cnt == 5'd31) || (mplier[WORD_W-1:1] == '0);
    if (state == MUL_RUN) begin
      alu_portA  = acc;
      alu_portB  = mcand;
      alu_aluOp  = ALU_ADD;
    end else begin
      alu_portA  = ex_portA;
      alu_portB  = ex_portB;
      alu_aluOp  = ex_aluOp;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state       <= MUL_IDLE;
      mcand       <= '0;
      mplier      <= '0;
      acc         <= '0;
      cnt         <= '0;
      mul.product <= '0;
      mul.busy    <= 1'b0;
      mul.done    <= 1'b0;
    end else begin
      mul.done <= 1'b0;
      case (state)
        MUL_IDLE: begin
          if (mul.start) begin
            mcand    <= mul.multiplicand;
            mplier   <= mul.multiplier;
            acc      <= '0;
            cnt      <= '0;
            mul.busy <= 1'b1;
            state    <= MUL_RUN;
          end
        end
        MUL_RUN: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 5'd1;
          if (run_exit) begin
            mul.product <= acc_next;
            mul.busy    <= 1'b0;
            mul.done    <= 1'b1;
            state       <= MUL_DONE;
          end
        end
        MUL_DONE: state <= MUL_IDLE;
        default:  state <= MUL_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mul_seq.sv
// Self-checking bench for alu_mul_seq: vector table plus scoreboard of expected products and RUN lengths.
module tb_alu_mul_seq;
  import cpu_types_pkg::*;

  logic   CLK;
  logic   nRST;
  word_t  ex_portA, ex_portB;
  aluop_t ex_aluOp;
  logic   ex_stall;
  word_t  alu_portA, alu_portB, alu_outPort;
  aluop_t alu_aluOp;
  logic   alu_negative, alu_overflow, alu_zero;

  alu_mul_seq_if bus ();

  alu_mul_seq dut (
    .CLK          (CLK),
    .nRST         (nRST),
    .mul          (bus),
    .ex_portA     (ex_portA),
    .ex_portB     (ex_portB),
    .ex_aluOp     (ex_aluOp),
    .ex_stall     (ex_stall),
    .alu_portA    (alu_portA),
    .alu_portB    (alu_portB),
    .alu_aluOp    (alu_aluOp),
    .alu_outPort  (alu_outPort),
    .alu_negative (alu_negative),
    .alu_overflow (alu_overflow),
    .alu_zero     (alu_zero)
  );

  // Behavioural stand-in for the shared ALU.
  always_comb begin
    case (alu_aluOp)
      ALU_ADD: alu_outPort = alu_portA + alu_portB;
      ALU_SUB: alu_outPort = alu_portA - alu_portB;
      ALU_AND: alu_outPort = alu_portA & alu_portB;
      ALU_OR:  alu_outPort = alu_portA | alu_portB;
      default: alu_outPort = alu_portA ^ alu_portB;
    endcase
    alu_negative = alu_outPort[31];
    alu_zero     = (alu_outPort == '0);
    alu_overflow = 1'b0;
  end

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    word_t a;
    word_t b;
    word_t prod;
    int    k;
  } vec_t;

  typedef struct {
    word_t prod;
    int    k;
  } exp_t;

  int    checks = 0;
  int    failures = 0;
  int    cyc = 0;
  exp_t  exq[$];
  logic  mon_en = 1'b0;
  int    busy_cnt = 0;
  word_t last_prod = '0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Scoreboard monitor: compares every done pulse against the oldest expectation.
  always @(negedge CLK) begin
    if (mon_en) begin
      chk("ex_stall_eq_busy", {31'd0, ex_stall}, {31'd0, bus.busy});
      if (bus.busy) begin
        busy_cnt++;
        chk("run_aluop_add", {28'd0, alu_aluOp}, {28'd0, ALU_ADD});
      end else begin
        chk("pass_portA", alu_portA, ex_portA);
        chk("pass_portB", alu_portB, ex_portB);
        chk("pass_aluop", {28'd0, alu_aluOp}, {28'd0, ex_aluOp});
      end
      if (bus.done) begin
        if (exq.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = exq.pop_front();
          chk("product", bus.product, e.prod);
          chk("run_cycles", busy_cnt, e.k);
          last_prod = e.prod;
        end
        busy_cnt = 0;
      end else begin
        chk("product_hold", bus.product, last_prod);
      end
    end
  end

  task automatic wait_done();
    int i;
    for (i = 0; i < 40; i++) begin
      @(negedge CLK);
      if (bus.done) break;
    end
    if (i == 40) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_vec(input word_t a, input word_t b, input word_t p, input int k);
    exp_t e;
    @(posedge CLK); #1;
    ex_portA = $urandom;
    ex_portB = $urandom;
    ex_aluOp = ($urandom_range(0, 1) == 0) ? ALU_SUB : ALU_OR;
    bus.start = 1'b1;
    bus.multiplicand = a;
    bus.multiplier = b;
    e.prod = p;
    e.k = k;
    exq.push_back(e);
    @(posedge CLK); #1;
    bus.start = 1'b0;
    bus.multiplicand = $urandom;
    bus.multiplier = $urandom;
    wait_done();
  endtask

  vec_t vecs[8];

  initial begin
    vecs[0] = '{32'd6,         32'd7,         32'd42,        3};
    vecs[1] = '{32'hFFFFFFFF,  32'd0,         32'd0,         1};
    vecs[2] = '{32'hFFFFFFFF,  32'hFFFFFFFF,  32'h00000001,  32};
    vecs[3] = '{32'hFFFFFFFF,  32'd2,         32'hFFFFFFFE,  2};
    vecs[4] = '{32'h12345678,  32'h00000100,  32'h34567800,  9};
    vecs[5] = '{32'h00010000,  32'h00010000,  32'h00000000,  17};
    vecs[6] = '{32'd0,         32'h80000000,  32'd0,         32};
    vecs[7] = '{32'd1000,      32'd1,         32'd1000,      1};

    nRST = 1'b0;
    bus.start = 1'b0;
    bus.multiplicand = '0;
    bus.multiplier = '0;
    ex_portA = 32'd5;
    ex_portB = 32'd3;
    ex_aluOp = ALU_ADD;
    repeat (2) @(posedge CLK);
    #2;
    chk("rst_product", bus.product, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_stall", {31'd0, ex_stall}, 32'd0);
    chk("rst_portA", alu_portA, 32'd5);
    chk("rst_portB", alu_portB, 32'd3);
    chk("rst_aluop", {28'd0, alu_aluOp}, {28'd0, ALU_ADD});
    @(negedge CLK);
    nRST = 1'b1;
    mon_en = 1'b1;

    for (int i = 0; i < 8; i++) run_vec(vecs[i].a, vecs[i].b, vecs[i].prod, vecs[i].k);

    // start held high: one accept every k+2 cycles; RUN-time operand changes must be ignored.
    begin
      exp_t e;
      int   ndone;
      int   last_cyc;
      e.prod = 32'd15;
      e.k = 3;
      repeat (3) exq.push_back(e);
      @(posedge CLK); #1;
      bus.start = 1'b1;
      bus.multiplicand = 32'd3;
      bus.multiplier = 32'd5;
      ndone = 0;
      last_cyc = 0;
      for (int i = 0; i < 40 && ndone < 3; i++) begin
        @(posedge CLK); #1;
        if (bus.busy) begin
          bus.multiplicand = $urandom;
          bus.multiplier = $urandom;
        end else begin
          bus.multiplicand = 32'd3;
          bus.multiplier = 32'd5;
        end
        if (bus.done) begin
          if (ndone > 0) chk("held_start_period", cyc - last_cyc, 32'd5);
          last_cyc = cyc;
          ndone++;
          if (ndone == 3) bus.start = 1'b0;
        end
      end
      bus.start = 1'b0;
      chk("held_start_dones", ndone, 32'd3);
      @(negedge CLK);
    end

    // Reset in the middle of a 32-cycle multiply aborts it without a done pulse.
    @(posedge CLK); #1;
    bus.start = 1'b1;
    bus.multiplicand = 32'hFFFFFFFF;
    bus.multiplier = 32'hFFFFFFFF;
    @(posedge CLK); #1;
    bus.start = 1'b0;
    repeat (9) @(posedge CLK);
    #2;
    chk("pre_rst_busy", {31'd0, bus.busy}, 32'd1);
    mon_en = 1'b0;
    nRST = 1'b0;
    #1;
    chk("abort_busy", {31'd0, bus.busy}, 32'd0);
    chk("abort_done", {31'd0, bus.done}, 32'd0);
    chk("abort_product", bus.product, 32'd0);
    chk("abort_pass_portA", alu_portA, ex_portA);
    @(negedge CLK);
    nRST = 1'b1;
    busy_cnt = 0;
    last_prod = '0;
    mon_en = 1'b1;
    repeat (40) @(negedge CLK);
    chk("abort_no_done_busy", {31'd0, bus.busy}, 32'd0);
    run_vec(32'd2, 32'd2, 32'd4, 2);

    repeat (2) @(negedge CLK);
    mon_en = 1'b0;
    chk("scoreboard_empty", exq.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
